// File: rtl/cpu6_bus_pkg.sv
// cpu6_bus_pkg: shared state encoding, owner codes and parameter defaults for the CPU6 bus arbiter
package cpu6_bus_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_DONE} state_t;
  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_CPU = 2'b01;
  localparam logic [1:0] OWNER_DMA = 2'b10;
  localparam int WAIT_STATES_DEF = 2;
  localparam int DMA_BURST_MAX_DEF = 4;
  localparam int TIMEOUT_DEF = 255;
endpackage

// File: rtl/cpu6_bus_arbiter.sv
// cpu6_bus_arbiter: CPU/DMA memory-bus arbiter with ADDR-WAIT-DONE cycle sequencing, wait states and timeout
module cpu6_bus_arbiter
  import cpu6_bus_pkg::*;
#(
  parameter int WAIT_STATES = WAIT_STATES_DEF,
  parameter int DMA_BURST_MAX = DMA_BURST_MAX_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_done,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic [7:0]  dma_rdata,
  output logic        dma_done,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_drive,
  input  logic [7:0]  mem_rdata,
  output logic        mem_oe,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic        bus_err,
  output logic [1:0]  owner
);
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_STATES - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  localparam logic [3:0] BURST_MAX = 4'(DMA_BURST_MAX);
  state_t state, state_n;
  logic we_r, we_n, dma_win, any_req, ok, tmo;
  logic [7:0] count;
  logic [3:0] dma_streak;
  always_comb begin
    any_req = cpu_req | dma_req;
    dma_win = dma_req & ~(cpu_req & (dma_streak == BURST_MAX));
    we_n = state == S_IDLE ? (dma_win ? dma_we : cpu_we) : we_r;
    ok = state == S_WAIT && count >= WAIT_LAST && mem_ready;
    tmo = state == S_WAIT && !ok && count == TIMEOUT_LAST;
    state_n = state == S_IDLE ? (any_req ? S_ADDR : S_IDLE) :
              state == S_ADDR ? S_WAIT :
              state == S_WAIT ? ((ok || tmo) ? S_DONE : S_WAIT) : S_IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      owner <= OWNER_NONE;
      dma_streak <= '0;
      count <= '0;
      we_r <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_oe <= 1'b0;
      mem_we <= 1'b0;
      mem_drive <= 1'b0;
      cpu_done <= 1'b0;
      dma_done <= 1'b0;
      bus_err <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      state <= state_n;
      we_r <= we_n;
      count <= state == S_WAIT ? count + 8'd1 : '0;
      mem_oe <= state_n != S_IDLE && !we_n;
      mem_drive <= state_n != S_IDLE && we_n;
      mem_we <= state_n == S_WAIT && we_r;
      cpu_done <= state_n == S_DONE && owner == OWNER_CPU;
      dma_done <= state_n == S_DONE && owner == OWNER_DMA;
      bus_err <= tmo;
      owner <= state_n == S_IDLE ? OWNER_NONE :
               state == S_IDLE ? (dma_win ? OWNER_DMA : OWNER_CPU) : owner;
      if (state == S_IDLE) begin
        dma_streak <= dma_win ? dma_streak + 4'(dma_streak != 4'hf) : '0;
        if (any_req) begin
          mem_addr <= dma_win ? dma_addr : cpu_addr;
          mem_wdata <= dma_win ? dma_wdata : cpu_wdata;
        end
      end
      if (ok && !we_r && owner == OWNER_CPU) cpu_rdata <= mem_rdata;
      if (ok && !we_r && owner == OWNER_DMA) dma_rdata <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_cpu6_bus_arbiter.sv
// tb_cpu6_bus_arbiter: randomized transaction-level check of cpu6_bus_arbiter against a reference model
module tb_cpu6_bus_arbiter;
  import cpu6_bus_pkg::*;
  localparam int WS = 2, BM = 4, TO = 8;
  logic clock = 1'b0, reset = 1'b1;
  logic cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
  logic [15:0] cpu_addr = '0, dma_addr = '0;
  logic [7:0] cpu_wdata = '0, dma_wdata = '0, mem_rdata = '0;
  logic mem_ready = 1'b0;
  logic [7:0] cpu_rdata, dma_rdata, mem_wdata;
  logic cpu_done, dma_done, mem_drive, mem_oe, mem_we, bus_err;
  logic [15:0] mem_addr;
  logic [1:0] owner;
  int n_checks = 0, n_fail = 0, streak = 0;
  logic [7:0] m_crd = '0, m_drd = '0, m_wdata = '0;
  logic [15:0] m_addr = '0;
  always #5 clock = ~clock;
  cpu6_bus_arbiter #(.WAIT_STATES(WS), .DMA_BURST_MAX(BM), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_done(dma_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_drive(mem_drive), .mem_rdata(mem_rdata),
    .mem_oe(mem_oe), .mem_we(mem_we), .mem_ready(mem_ready), .bus_err(bus_err), .owner(owner)
  );
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic idle_chk();
    chk("idle_owner", 16'(owner), 16'(OWNER_NONE));
    chk("idle_strobes", 16'({mem_oe, mem_we, mem_drive}), '0);
    chk("idle_pulses", 16'({cpu_done, dma_done, bus_err}), '0);
    chk("idle_addr", mem_addr, m_addr);
    chk("idle_wdata", 16'(mem_wdata), 16'(m_wdata));
    chk("idle_cpu_rdata", 16'(cpu_rdata), 16'(m_crd));
    chk("idle_dma_rdata", 16'(dma_rdata), 16'(m_drd));
  endtask
  task automatic scramble();
    cpu_we = 1'($urandom); dma_we = 1'($urandom);
    cpu_addr = 16'($urandom); dma_addr = 16'($urandom);
    cpu_wdata = 8'($urandom); dma_wdata = 8'($urandom);
  endtask
  task automatic gap();
    @(negedge clock);
    idle_chk();
    cpu_req = 1'b0; dma_req = 1'b0;
    scramble();
    mem_ready = 1'($urandom); mem_rdata = 8'($urandom);
    streak = 0;
  endtask
  task automatic txn(input bit rc, rd, wc, wd, input logic [15:0] ac, ad,
                     input logic [7:0] xc, xd, input int n, input bit drop, input logic [7:0] rdv);
    bit dwin, w, tmo;
    int c, dn;
    logic [1:0] own;
    @(negedge clock);
    idle_chk();
    dwin = rd && !(rc && streak == BM);
    streak = dwin ? (streak == 15 ? 15 : streak + 1) : 0;
    own = dwin ? OWNER_DMA : OWNER_CPU;
    w = dwin ? wd : wc;
    m_addr = dwin ? ad : ac;
    m_wdata = dwin ? xd : xc;
    tmo = n > TO - 1;
    c = tmo ? TO - 1 : (n > WS - 1 ? n : WS - 1);
    dn = c + 3;
    cpu_req = rc; dma_req = rd; cpu_we = wc; dma_we = wd;
    cpu_addr = ac; dma_addr = ad; cpu_wdata = xc; dma_wdata = xd;
    mem_ready = 1'($urandom); mem_rdata = 8'($urandom);
    for (int k = 1; k <= dn; k++) begin
      @(negedge clock);
      if (k == dn && !w && !tmo) begin
        if (dwin) m_drd = rdv;
        else m_crd = rdv;
      end
      chk("owner", 16'(owner), 16'(own));
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", 16'(mem_wdata), 16'(m_wdata));
      chk("mem_oe", 16'(mem_oe), 16'(!w));
      chk("mem_drive", 16'(mem_drive), 16'(w));
      chk("mem_we", 16'(mem_we), 16'(w && k >= 2 && k < dn));
      chk("cpu_done", 16'(cpu_done), 16'(k == dn && !dwin));
      chk("dma_done", 16'(dma_done), 16'(k == dn && dwin));
      chk("bus_err", 16'(bus_err), 16'(k == dn && tmo));
      chk("cpu_rdata", 16'(cpu_rdata), 16'(m_crd));
      chk("dma_rdata", 16'(dma_rdata), 16'(m_drd));
      cpu_req = k == dn ? 1'b0 : (dwin ? rc : !drop);
      dma_req = k == dn ? 1'b0 : (dwin ? !drop : rd);
      scramble();
      mem_ready = k >= 2 ? (k - 2 >= n) : 1'($urandom);
      mem_rdata = k == dn - 1 ? rdv : rdv ^ 8'($urandom_range(1, 255));
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    int sel, n;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    txn(1, 0, 0, 0, 16'h0100, 16'h0000, 8'h00, 8'h00, 0, 0, 8'hA5);
    txn(0, 1, 0, 1, 16'h0000, 16'h8000, 8'h00, 8'h3C, 4, 0, 8'h77);
    txn(1, 0, 0, 0, 16'h1234, 16'h0000, 8'h00, 8'h00, 255, 0, 8'h5A);
    @(negedge clock);
    idle_chk();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2222; mem_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; cpu_req = 1'b0;
    m_crd = '0; m_drd = '0; m_addr = '0; m_wdata = '0; streak = 0;
    idle_chk();
    gap();
    txn(1, 0, 0, 0, 16'h4444, 16'h0000, 8'h00, 8'h00, 0, 0, 8'hC3);
    txn(1, 0, 0, 0, 16'h5555, 16'h0000, 8'h00, 8'h00, 0, 1, 8'h96);
    gap();
    for (int i = 0; i < 6; i++)
      txn(1, 1, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
          8'($urandom), 8'($urandom), 0, 0, 8'($urandom));
    for (int i = 0; i < 120; i++) begin
      sel = $urandom_range(1, 3);
      n = $urandom_range(0, 9) == 0 ? 8 + $urandom_range(0, 4) : $urandom_range(0, 5);
      if ($urandom_range(0, 3) == 0) gap();
      txn(sel[0], sel[1], 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
          8'($urandom), 8'($urandom), n, $urandom_range(0, 3) == 0, 8'($urandom));
    end
    gap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
